seq_count_ctrl: RTL
===================

Name: seq_count_ctrl

Overview:
Sequencing controller for the skip-state 3-bit counter (sequence 000→001→010→100→101→110→000; states 011 and 111 unused). It owns the counter register and runs it in three ways: bounded runs of a programmed number of steps, free-run until stopped, or single steps. It also handles parallel load with legalization of unused codes, and reports busy, done, wrap and illegal-load status to the surrounding control logic.

Parameters:
LEN_W, 8, width of run_len and steps_left; maximum bounded run is 2^LEN_W-1 steps.

Ports:
clk  in  1  clock, rising-edge.
rstn  in  1  asynchronous, active-low reset.
start  in  1  begin a run; sampled only in IDLE.
stop  in  1  abort a run; sampled in RUN.
step_req  in  1  advance one step; sampled only in IDLE.
free_run  in  1  1 = run until stop; 0 = bounded by run_len; latched at start.
run_len  in  LEN_W  number of advances in a bounded run; latched at start.
load  in  1  parallel load request; sampled only in IDLE.
load_val  in  3  value to load.
count  out  3  counter value.
busy  out  1  1 while in RUN.
done  out  1  one-cycle pulse when a bounded run completes.
wrap  out  1  one-cycle pulse on any 110→000 advance.
illegal  out  1  sticky flag: an unused code (011/111) was loaded.
steps_left  out  LEN_W  remaining advances in a bounded run; 0 otherwise.

Behaviour:
- Reset (async, rstn=0): state IDLE, count=000, busy=0, done=0, wrap=0, illegal=0, steps_left=0. Takes effect immediately. Asserting reset mid-run aborts the run with no done pulse.
- Advance function: 0→1, 1→2, 2→4, 4→5, 5→6, 6→0. Defensive entries 3→4 and 7→0 exist but are unreachable, because loads are legalized.
- All outputs are registered. done and wrap are high only for the cycle after the edge that caused them.

FSM states: IDLE, RUN.

IDLE. Input priority is start > load > step_req; stop is ignored.
- start, bounded mode, run_len=0: stay in IDLE, count unchanged, done=1 on the next cycle, illegal cleared.
- start otherwise: go to RUN, latch free_run, set steps_left=run_len (0 if free_run), clear illegal. count does not change on the accepting edge.
- load with legal load_val: count=load_val.
- load with load_val=011 or 111: count=000 and illegal=1. illegal stays set until the next accepted start or reset.
- step_req: count advances once; wrap pulses if the advance is 6→0.

RUN. stop has priority over advancing; start, load and step_req are ignored.
- stop=1: go to IDLE on that edge with no advance, no done, steps_left=0.
- Otherwise, each edge advances count.
- Bounded mode: steps_left decrements on each advance. On the advance where steps_left=1, go to IDLE, set steps_left=0 and done=1.
- Timing: start accepted at edge k with run_len=N gives advances at edges k+1..k+N. busy is high from after edge k until after edge k+N. done is high for the cycle after edge k+N.
- Free-run mode: advances until stop; steps_left stays 0.
- run_len and free_run changes during RUN have no effect.
- stop and the final bounded advance on the same edge: stop wins, so no advance and no done.

Width rules:
- steps_left never underflows.
- count never holds 011 or 111 outside reset.

Test Plan:
1. Reset, then start with free_run=0, run_len=6 → count 1,2,4,5,6,0 on consecutive edges; busy high for 6 cycles; wrap pulses once (on 6→0); done pulses once, coinciding with busy falling; steps_left counts 6..1 then 0.
2. Start with run_len=0, bounded → done pulses one cycle later; busy never rises; count stays 000.
3. free_run=1, start, stop asserted on the 4th cycle after acceptance → count 1,2,4 then held at 4; busy falls; no done; a second stop in IDLE has no effect.
4. IDLE: load 011 → count=000, illegal=1; load 101 → count=101, illegal still 1; start with run_len=2 → illegal cleared, count 6,0, wrap=1, done=1.
5. IDLE at 000: three step_req cycles → 1,2,4. start and load together → start wins, load ignored. run_len=3 with stop asserted on the edge of the final advance → no done, count holds at the value before that edge.
6. rstn asserted asynchronously mid bounded run (count=5) → count=000, busy=0, steps_left=0 immediately without a clock edge; no done after release; a fresh start runs normally.

Source files
------------

// File: rtl/seq_count_ctrl.sv
// Sequencing controller for the skip-state counter 0->1->2->4->5->6->0.
// Runs bounded, free-running or single-step advances and legalizes parallel loads.
module seq_count_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             step_req,
  input  logic             free_run,
  input  logic [LEN_W-1:0] run_len,
  input  logic             load,
  input  logic [2:0]       load_val,
  output logic [2:0]       count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             illegal,
  output logic [LEN_W-1:0] steps_left
);

  // Handshake: start/stop/step_req/load are level requests sampled on each
  // rising edge in the state that honours them; there is no ready, and busy
  // tells the requester that start/step_req/load are currently ignored.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [2:0]       count_n;
  logic [LEN_W-1:0] steps_n;
  logic             done_n, wrap_n, illegal_n;
  logic             free_q, free_n;

  function automatic logic [2:0] adv(input logic [2:0] c);
    case (c)
      3'd0:    adv = 3'd1;
      3'd1:    adv = 3'd2;
      3'd2:    adv = 3'd4;
      3'd3:    adv = 3'd4;
      3'd4:    adv = 3'd5;
      3'd5:    adv = 3'd6;
      default: adv = 3'd0;
    endcase
  endfunction

  // busy is the state register itself, so it is registered like every output
  assign busy = (state == RUN);

  always_comb begin
    state_n   = state;
    count_n   = count;
    steps_n   = steps_left;
    done_n    = 1'b0;
    wrap_n    = 1'b0;
    illegal_n = illegal;
    free_n    = free_q;
    case (state)
      IDLE: begin
        if (start) begin
          illegal_n = 1'b0;
          if (!free_run && run_len == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            free_n  = free_run;
            steps_n = free_run ? '0 : run_len;
          end
        end else if (load) begin
          if (load_val == 3'd3 || load_val == 3'd7) begin
            count_n   = 3'd0;
            illegal_n = 1'b1;
          end else begin
            count_n = load_val;
          end
        end else if (step_req) begin
          count_n = adv(count);
          wrap_n  = (count == 3'd6);
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          steps_n = '0;
        end else begin
          count_n = adv(count);
          wrap_n  = (count == 3'd6);
          if (!free_q) begin
            // <= 1 rather than == 1 keeps steps_left from ever underflowing
            if (steps_left <= LEN_W'(1)) begin
              state_n = IDLE;
              steps_n = '0;
              done_n  = 1'b1;
            end else begin
              steps_n = steps_left - LEN_W'(1);
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      count      <= 3'd0;
      steps_left <= '0;
      done       <= 1'b0;
      wrap       <= 1'b0;
      illegal    <= 1'b0;
      free_q     <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      steps_left <= steps_n;
      done       <= done_n;
      wrap       <= wrap_n;
      illegal    <= illegal_n;
      free_q     <= free_n;
    end
  end

endmodule
